// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction fetch FSM with alignment, timeout and bus-error faults
module instruction_fetch #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        halt,
  input  logic        fetch_start,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_consume,
  output logic [5:0]  opcode,
  output logic [25:0] jump_target,
  output logic        busy,
  output logic        fetch_fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, FAULT} state_t;
  state_t state, state_nx;
  logic [7:0] wait_cnt;
  logic accept, timeout, misaligned;
  assign misaligned = pc[1:0] != 2'b00;
  assign accept = (state == IDLE || (state == HOLD && instr_consume)) && fetch_start && !halt;
  // mem_ack in the final wait cycle wins over the timeout
  assign timeout = state == WAIT && !mem_ack && wait_cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = misaligned ? FAULT : WAIT;
    else if (state == HOLD && instr_consume) state_nx = IDLE;
    else if (state == WAIT && mem_ack) state_nx = mem_err ? FAULT : HOLD;
    else if (timeout) state_nx = FAULT;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      mem_addr    <= 32'h0100_0000;
      instr       <= '0;
      fault_code  <= 2'b00;
      fetch_count <= '0;
      wait_cnt    <= '0;
    end else begin
      if (accept) begin
        mem_addr <= pc;
        wait_cnt <= '0;
        if (misaligned) fault_code <= 2'b01;
      end
      if (state == WAIT) begin
        if (mem_ack && !mem_err) begin
          instr       <= mem_rdata;
          fetch_count <= fetch_count + 32'd1;
        end
        if (mem_ack && mem_err) fault_code <= 2'b11;
        if (!mem_ack) wait_cnt <= wait_cnt + 8'd1;
        if (timeout) fault_code <= 2'b10;
      end
    end
  assign mem_req     = state == WAIT;
  assign busy        = state == WAIT;
  assign fetch_fault = state == FAULT;
  // an instruction is held exactly while in HOLD; consuming it leaves HOLD
  assign instr_valid = state == HOLD;
  assign opcode      = instr[31:26];
  assign jump_target = instr[25:0];
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_instruction_fetch;
  localparam int TO = 16;
  logic clk = 0, rst = 0, halt = 0, fetch_start = 0, mem_ack = 0, mem_err = 0, instr_consume = 0;
  logic [31:0] pc = 0, mem_rdata = 0;
  logic mem_req, instr_valid, busy, fetch_fault;
  logic [31:0] mem_addr, instr, fetch_count;
  logic [5:0] opcode;
  logic [25:0] jump_target;
  logic [1:0] fault_code;
  int n_chk = 0, n_pass = 0;

  instruction_fetch #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .pc(pc), .halt(halt), .fetch_start(fetch_start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_err(mem_err), .instr(instr), .instr_valid(instr_valid), .instr_consume(instr_consume),
    .opcode(opcode), .jump_target(jump_target), .busy(busy), .fetch_fault(fetch_fault),
    .fault_code(fault_code), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // reference model: one outstanding request, one held word, sticky fault
  bit m_out, m_held, m_dead;
  int m_waited;
  logic [31:0] m_addr, m_instr, m_cnt;
  logic [1:0] m_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_update();
    if (!rst) begin
      m_out = 0; m_held = 0; m_dead = 0; m_waited = 0;
      m_addr = 32'h0100_0000; m_instr = 0; m_cnt = 0; m_code = 0;
    end else if (m_dead) begin
    end else if (m_out) begin
      if (mem_ack) begin
        m_out = 0;
        if (mem_err) begin m_dead = 1; m_code = 3; end
        else begin m_held = 1; m_instr = mem_rdata; m_cnt = m_cnt + 1; end
      end else begin
        m_waited++;
        if (m_waited == TO) begin m_out = 0; m_dead = 1; m_code = 2; end
      end
    end else if (!m_held || instr_consume) begin
      m_held = 0;
      if (fetch_start && !halt) begin
        m_addr = pc;
        if (pc[1:0] != 0) begin m_dead = 1; m_code = 1; end
        else begin m_out = 1; m_waited = 0; end
      end
    end
  endtask

  task automatic compare();
    chk("mem_req", 32'(mem_req), 32'(m_out));
    chk("busy", 32'(busy), 32'(m_out));
    chk("instr_valid", 32'(instr_valid), 32'(m_held));
    chk("fetch_fault", 32'(fetch_fault), 32'(m_dead));
    chk("fault_code", 32'(fault_code), 32'(m_code));
    chk("mem_addr", mem_addr, m_addr);
    chk("instr", instr, m_instr);
    chk("opcode", 32'(opcode), 32'(m_instr >> 26));
    chk("jump_target", 32'(jump_target), m_instr & 32'h03FF_FFFF);
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic quiet();
    rst = 1; halt = 0; fetch_start = 0; mem_ack = 0; mem_err = 0; instr_consume = 0;
  endtask

  task automatic do_reset();
    quiet(); rst = 0; step(); rst = 1;
  endtask

  int n;
  int ack_pct;

  initial begin
    do_reset();
    chk("rst_addr", mem_addr, 32'h0100_0000);
    chk("rst_req", 32'(mem_req), 0);

    // basic fetch, 2-cycle latency
    quiet(); pc = 32'h0100_0000; fetch_start = 1; step();
    chk("b_req", 32'(mem_req), 1);
    quiet(); mem_ack = 1; mem_rdata = 32'h0800_0010; step();
    chk("b_valid", 32'(instr_valid), 1);
    chk("b_op", 32'(opcode), 32'h02);
    chk("b_jt", 32'(jump_target), 32'h10);
    chk("b_cnt", fetch_count, 1);

    // HOLD without consume keeps word and ignores start
    quiet(); fetch_start = 1; pc = 32'h0200_0000; step(); step();
    chk("h_stable", 32'(instr_valid), 1);
    // back-to-back fetch
    quiet(); instr_consume = 1; fetch_start = 1; pc = 32'h0100_0004; step();
    chk("bb_req", 32'(mem_req), 1);
    chk("bb_addr", mem_addr, 32'h0100_0004);
    chk("bb_valid", 32'(instr_valid), 0);
    quiet(); mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; step();
    // consume with halt -> IDLE
    quiet(); instr_consume = 1; fetch_start = 1; halt = 1; pc = 32'h0100_0008; step();
    chk("halt_req", 32'(mem_req), 0);
    chk("halt_valid", 32'(instr_valid), 0);

    // bus error keeps instr and count
    quiet(); fetch_start = 1; pc = 32'h0100_000C; step();
    quiet(); mem_ack = 1; mem_err = 1; mem_rdata = 32'h1234_5678; step();
    chk("err_code", 32'(fault_code), 3);
    chk("err_instr", instr, 32'hDEAD_BEEF);
    chk("err_cnt", fetch_count, 2);

    // misaligned
    do_reset();
    quiet(); fetch_start = 1; pc = 32'h0100_0002; step();
    quiet();
    for (int i = 0; i < 5; i++) begin fetch_start = 1; pc = 32'h0100_0000; step(); end
    chk("mis_req", 32'(mem_req), 0);
    chk("mis_code", 32'(fault_code), 1);
    chk("mis_fault", 32'(fetch_fault), 1);

    // timeout: request held exactly TO cycles
    do_reset();
    quiet(); fetch_start = 1; pc = 32'h0100_0010; step();
    quiet(); n = 0;
    for (int i = 0; i < TO + 4; i++) begin n += int'(mem_req); step(); end
    chk("to_len", n, TO);
    chk("to_code", 32'(fault_code), 2);
    // ack on the last allowed cycle beats timeout
    do_reset();
    quiet(); fetch_start = 1; pc = 32'h0100_0014; step();
    quiet();
    for (int i = 0; i < TO - 1; i++) step();
    mem_ack = 1; mem_rdata = 32'hCAFE_0001; step();
    chk("late_valid", 32'(instr_valid), 1);
    chk("late_fault", 32'(fetch_fault), 0);

    // reset during WAIT, then stray ack
    do_reset();
    quiet(); fetch_start = 1; pc = 32'h0100_0018; step();
    quiet(); step();
    rst = 0; step();
    chk("rw_req", 32'(mem_req), 0);
    quiet(); mem_ack = 1; mem_rdata = 32'h5555_AAAA; step();
    chk("rw_valid", 32'(instr_valid), 0);
    chk("rw_instr", instr, 0);

    // randomized traffic
    ack_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 59) != 0;
      if (!rst) ack_pct = ($urandom_range(0, 2) == 0) ? 4 : $urandom_range(20, 80);
      fetch_start = $urandom_range(0, 1);
      halt = $urandom_range(0, 4) == 0;
      instr_consume = $urandom_range(0, 9) < 4;
      mem_ack = $urandom_range(0, 99) < ack_pct;
      mem_err = $urandom_range(0, 9) == 0;
      mem_rdata = $urandom;
      pc = {$urandom_range(0, 32'h3FFF_FFFF), ($urandom_range(0, 15) == 0) ? 2'(1 + $urandom_range(0, 2)) : 2'b00};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum number of WAIT cycles tolerated before a timeout fault (legal range 2..255).
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous and active-low (state reset when rst==0 at a rising clk edge).
REQ-004 pc  input  32  SHALL carry the fetch address from the program counter.
REQ-005 halt  input  1  SHALL carry the program counter halt flag; when 1, new fetches are blocked.
REQ-006 fetch_start  input  1  SHALL request a fetch of pc; sampled only in IDLE or HOLD.
REQ-007 mem_req  output  1  SHALL request an instruction-memory read.
REQ-008 mem_addr  output  32  SHALL carry the read address, stable while mem_req==1.
REQ-009 mem_ack  input  1  SHALL indicate mem_rdata/mem_err valid for the outstanding request.
REQ-010 mem_rdata  input  32  SHALL carry the instruction word, qualified by mem_ack.
REQ-011 mem_err  input  1  SHALL flag a bus error, qualified by mem_ack.
REQ-012 instr  output  32  SHALL carry the registered instruction word.
REQ-013 instr_valid  output  1  SHALL be 1 when instr holds an unconsumed instruction.
REQ-014 instr_consume  input  1  SHALL acknowledge instr; effective only when instr_valid==1.
REQ-015 opcode  output  6  SHALL equal instr[31:26], combinationally.
REQ-016 jump_target  output  26  SHALL equal instr[25:0], combinationally.
REQ-017 busy  output  1  SHALL be 1 in WAIT.
REQ-018 fetch_fault  output  1  SHALL be 1 in FAULT.
REQ-019 fault_code  output  2  SHALL hold 00 none, 01 misaligned, 10 timeout, 11 bus error.
REQ-020 fetch_count  output  32  SHALL count successful fetches.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, WAIT, HOLD, FAULT.
REQ-022 IDLE: on fetch_start==1 and halt==0, the block SHALL latch pc into mem_addr and go to FAULT with code 01 if pc[1:0]!=00, else go to WAIT.
REQ-023 mem_req SHALL be 1 in WAIT and only in WAIT; mem_req asserts the cycle after fetch_start is accepted (1-cycle latency).
REQ-024 A 8-bit wait counter SHALL clear on WAIT entry and increment each WAIT cycle with mem_ack==0.
REQ-025 WAIT with mem_ack==1, mem_err==0: instr<=mem_rdata, instr_valid<=1, fetch_count increments (wrapping 0xFFFFFFFF->0), next state HOLD.
REQ-026 WAIT with mem_ack==1, mem_err==1: instr unchanged, fault_code<=11, next state FAULT.
REQ-027 WAIT with mem_ack==0 and counter==TIMEOUT_CYCLES-1: fault_code<=10, next state FAULT; mem_ack in that same cycle SHALL take priority over timeout.
REQ-028 fetch_start and halt SHALL be ignored in WAIT; an outstanding request is never aborted except by reset.
REQ-029 HOLD: instr_consume==1 clears instr_valid; if fetch_start==1 and halt==0 in the same cycle, the new fetch SHALL be accepted per REQ-022 (back-to-back), else next state IDLE.
REQ-030 HOLD without instr_consume SHALL keep instr and instr_valid stable, ignoring fetch_start.
REQ-031 FAULT SHALL be sticky until reset; mem_req==0, instr_valid==0, fetch_start ignored.
REQ-032 Minimum fetch-to-valid latency SHALL be 2 cycles (accept, then ack in first WAIT cycle).

Reset
REQ-033 On rst==0 at a clk edge: state IDLE, mem_req=0, mem_addr=0x01000000, instr=0, instr_valid=0, busy=0, fetch_fault=0, fault_code=00, fetch_count=0, wait counter=0.
REQ-034 Reset mid-WAIT SHALL drop mem_req the following cycle; a late mem_ack after reset SHALL be ignored in IDLE.

Verification
REQ-035 pc=0x01000000, fetch_start pulse, mem_ack next cycle with rdata=0x08000010 -> instr_valid=1 after 2 cycles, opcode=000010, jump_target=0x0000010, fetch_count=1.
REQ-036 pc=0x01000002, fetch_start -> no mem_req, fetch_fault=1, fault_code=01, persists until rst=0.
REQ-037 Valid fetch, mem_ack never asserted -> mem_req high exactly 16 cycles, then fetch_fault=1, fault_code=10; ack on 16th cycle instead -> HOLD, no fault.
REQ-038 mem_ack with mem_err=1 -> fault_code=11, instr unchanged, fetch_count unchanged.
REQ-039 In HOLD, instr_consume and fetch_start same cycle with pc=0x01000004 -> instr_valid=0, mem_req=1 next cycle with mem_addr=0x01000004; with halt=1 instead -> IDLE, no mem_req.
REQ-040 rst=0 asserted during WAIT, then mem_ack pulsed -> all outputs at REQ-033 values, instr_valid stays 0.
